merge2_4p: RTL and testbench
============================

Name: merge2_4p

Overview:
- Clocked two-input merge for 4-phase bundled-data channels; the inverse of the copy fork.
- Accepts tokens from input channels L0 and L1, arbitrates round-robin, and forwards each token exactly once on output channel R.
- Tags each forwarded token with its source port and counts completed transfers.
- Sits where two PE result streams must share one downstream link.

Parameters:
- WIDTH, 8, data bits per token.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- L0_req  input  1  channel L0 request (4-phase).
- L0_data  input  WIDTH  channel L0 bundled data; valid while L0_req=1.
- L0_ack  output  1  channel L0 acknowledge.
- L1_req  input  1  channel L1 request.
- L1_data  input  WIDTH  channel L1 bundled data.
- L1_ack  output  1  channel L1 acknowledge.
- R_req  output  1  channel R request.
- R_data  output  WIDTH  channel R data; registered, stable while R_req=1.
- R_src  output  1  source of current R token (0=L0, 1=L1); registered with R_data.
- R_ack  input  1  channel R acknowledge.
- xfer_cnt  output  CNT_W  completed input handshakes; wraps modulo 2^CNT_W.

Behaviour:
- All req/ack inputs are driven synchronous to clk; no internal synchronizers.
- Reset (rst_n=0, asynchronous): state=IDLE.
  - L0_ack=0, L1_ack=0, R_req=0, R_data=0, R_src=0, xfer_cnt=0.
  - Priority pointer = L0.
- The outputs L0_ack, L1_ack, R_req, R_data, R_src and xfer_cnt are all registers.
- States:
  - IDLE:
    - Sample L0_req and L1_req.
    - If exactly one is high, grant it.
    - If both are high, grant the priority-pointer port.
    - On grant: latch that port's data into R_data, set R_src=port, set R_req=1, go to WAIT_ACK.
    - If neither is high: hold.
  - WAIT_ACK:
    - Hold R_req=1, R_data, R_src.
    - When R_ack=1: R_req<=0, granted Lx_ack<=1, go to WAIT_RTZ.
  - WAIT_RTZ:
    - Wait until R_ack=0 AND granted Lx_req=0, sampled in the same cycle.
    - Then: Lx_ack<=0, xfer_cnt<=xfer_cnt+1, pointer<=other port, go to IDLE.
- Latency:
  - Lx_req rising, sampled at edge n -> R_req=1 after edge n.
  - R_ack=1 sampled at edge m -> Lx_ack=1 and R_req=0 after edge m.
- Minimum cycle: 3 clocks per token with an immediately responsive environment.
- The non-granted input is untouched; its ack stays 0 and its req may stay high indefinitely.
- R_data is never updated outside IDLE, so the non-granted L data changing has no effect.
- Fairness:
  - The pointer toggles only after a completed transfer.
  - With both reqs continuously high, grants alternate L0, L1, L0, ...
  - The pointer toggles even when only one port was active, so after an L1 transfer a simultaneous request favors L0.
- Lx_req falling before its ack (protocol violation): ignored; the FSM still waits for R_ack and completes.
- R_ack=1 in IDLE: ignored.
- xfer_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-handshake: immediate return to reset values; any in-flight token is dropped. The environment must also reset.

Test Plan:
- Single L0 token:
  - Stimulus: L0_data=0x5A, L0_req=1; R bucket acks 1 cycle after R_req.
  - Required: R_data=0x5A, R_src=0, L0_ack pulses once, L1_ack stays 0, xfer_cnt=1.
- Simultaneous requests, both reqs held:
  - Stimulus: L0=0x11, L1=0x22 for 4 tokens; L0 sends 0x11, 0x13; L1 sends 0x22, 0x24.
  - Required: R sequence 0x11(src0), 0x22(src1), 0x13(src0), 0x24(src1); xfer_cnt=4.
- Backpressure:
  - Stimulus: R_ack delayed 10 cycles with L1_data=0xC3.
  - Required: R_req and R_data=0xC3 stable for all 10 cycles; L1_ack=0 until R_ack is seen.
  - Changing L0_data during the wait does not alter R_data.
- Slow input return-to-zero:
  - Stimulus: L0_req held high 5 cycles after L0_ack.
  - Required: FSM stays in WAIT_RTZ; no new grant; L0_ack deasserts 1 cycle after L0_req=0.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 transfers.
  - Required: xfer_cnt reads 15 after 15 transfers, 0 after 16, 1 after 17.
- Asynchronous reset mid-transfer:
  - Stimulus: rst_n low between clock edges while in WAIT_ACK.
  - Required: R_req, L0_ack, L1_ack, R_data and xfer_cnt = 0 immediately; the next token is granted to L0 on a simultaneous request.

Source files
------------

// File: rtl/merge2_4p_if.sv
// Channel bundle for merge2_4p: two 4-phase bundled-data inputs (L0, L1) and one output (R).
// slave = the merge block, master = the surrounding environment.
interface merge2_4p_if #(
    parameter int WIDTH = 8
);
    logic             L0_req;
    logic [WIDTH-1:0] L0_data;
    logic             L0_ack;
    logic             L1_req;
    logic [WIDTH-1:0] L1_data;
    logic             L1_ack;
    logic             R_req;
    logic [WIDTH-1:0] R_data;
    logic             R_src;
    logic             R_ack;

    modport slave (
        input  L0_req, L0_data, L1_req, L1_data, R_ack,
        output L0_ack, L1_ack, R_req, R_data, R_src
    );

    modport master (
        output L0_req, L0_data, L1_req, L1_data, R_ack,
        input  L0_ack, L1_ack, R_req, R_data, R_src
    );
endinterface

// File: rtl/merge2_4p.sv
// Two-input round-robin merge for 4-phase bundled-data channels.
// Each token is forwarded once on R, tagged with its source port, and counted.
module merge2_4p #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    merge2_4p_if.slave       ch,
    output logic [CNT_W-1:0] xfer_cnt
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] WAIT_RTZ = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             src_q, src_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             rreq_q, rreq_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic sel;
    logic gnt_req;

    // Contention goes to the pointer; otherwise to whichever port is requesting.
    assign sel     = (ch.L0_req && ch.L1_req) ? ptr_q : ch.L1_req;
    assign gnt_req = src_q ? ch.L1_req : ch.L0_req;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data_d  = data_q;
        rreq_d  = rreq_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ch.L0_req || ch.L1_req) begin
                    src_d   = sel;
                    data_d  = sel ? ch.L1_data : ch.L0_data;
                    rreq_d  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ch.R_ack) begin
                    rreq_d  = 1'b0;
                    ack0_d  = ~src_q;
                    ack1_d  = src_q;
                    state_d = WAIT_RTZ;
                end
            end
            WAIT_RTZ: begin
                // Both sides must have returned to zero in the same sample.
                if (!ch.R_ack && !gnt_req) begin
                    ack0_d  = 1'b0;
                    ack1_d  = 1'b0;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    ptr_d   = ~src_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            src_q   <= 1'b0;
            data_q  <= '0;
            rreq_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
            rreq_q  <= rreq_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ch.L0_ack = ack0_q;
    assign ch.L1_ack = ack1_q;
    assign ch.R_req  = rreq_q;
    assign ch.R_data = data_q;
    assign ch.R_src  = src_q;
    assign xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_merge2_4p.sv
// Directed bench for merge2_4p: expected R tokens are queued as inputs are raised
// and compared when the DUT presents them on R.
module tb_merge2_4p;
    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic         src;
        logic [W-1:0] data;
    } tok_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] xfer_cnt;
    logic [CW-1:0] exp_cnt;
    tok_t          sb[$];
    int            errs = 0;
    int            checks = 0;

    merge2_4p_if #(.WIDTH(W)) ch();

    merge2_4p #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch       (ch),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic src, input logic [W-1:0] d);
        tok_t t;
        t.src  = src;
        t.data = d;
        sb.push_back(t);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        ch.L0_req = 1'b0; ch.L1_req = 1'b0; ch.R_ack = 1'b0;
        ch.L0_data = '0; ch.L1_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_r_req",  ch.R_req,  1'b0);
        chk("rst_r_data", ch.R_data, '0);
        chk("rst_r_src",  ch.R_src,  1'b0);
        chk("rst_l0_ack", ch.L0_ack, 1'b0);
        chk("rst_l1_ack", ch.L1_ack, 1'b0);
        chk("rst_cnt",    xfer_cnt,  '0);
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
    endtask

    // Serve one R token: compare against scoreboard, stall R_ack 'delay' cycles,
    // then complete the 4-phase handshake with the granted input held 'hold' cycles.
    task automatic token(input int delay, input int hold);
        tok_t         e;
        int           n;
        logic [W-1:0] d0;
        n = 0;
        while (!ch.R_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("r_req_timeout", ch.R_req, 1'b1);
        if (!ch.R_req) return;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("r_data", ch.R_data, e.data);
        chk("r_src",  ch.R_src,  e.src);
        d0 = ch.R_data;
        for (int i = 0; i < delay; i++) begin
            if (e.src && !ch.L0_req) ch.L0_data = ~ch.L0_data;
            else if (!e.src && !ch.L1_req) ch.L1_data = ~ch.L1_data;
            @(negedge clk);
            chk("bp_r_req",  ch.R_req,  1'b1);
            chk("bp_r_data", ch.R_data, d0);
            chk("bp_acks",   {ch.L1_ack, ch.L0_ack}, 2'b00);
        end
        ch.R_ack = 1'b1;
        @(negedge clk);
        chk("lx_ack_set", e.src ? ch.L1_ack : ch.L0_ack, 1'b1);
        chk("other_ack",  e.src ? ch.L0_ack : ch.L1_ack, 1'b0);
        chk("r_req_drop", ch.R_req, 1'b0);
        ch.R_ack = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rtz_ack_hold", e.src ? ch.L1_ack : ch.L0_ack, 1'b1);
            chk("rtz_no_grant", ch.R_req, 1'b0);
        end
        if (e.src) ch.L1_req = 1'b0;
        else       ch.L0_req = 1'b0;
        @(negedge clk);
        exp_cnt++;
        chk("lx_ack_clr", e.src ? ch.L1_ack : ch.L0_ack, 1'b0);
        chk("xfer_cnt", xfer_cnt, exp_cnt);
    endtask

    initial begin
        ch.L0_req = 1'b0; ch.L1_req = 1'b0; ch.R_ack = 1'b0;
        ch.L0_data = '0; ch.L1_data = '0;
        exp_cnt = '0;
        reset_dut();

        // Single L0 token, R_req one edge after the request is sampled
        ch.L0_data = 8'h5A; ch.L0_req = 1'b1; push(1'b0, 8'h5A);
        @(negedge clk);
        chk("req_latency", ch.R_req, 1'b1);
        token(1, 0);

        // Both inputs held: grants alternate starting at L0
        reset_dut();
        ch.L0_data = 8'h11; ch.L1_data = 8'h22;
        ch.L0_req = 1'b1; ch.L1_req = 1'b1;
        push(1'b0, 8'h11); push(1'b1, 8'h22);
        token(0, 0);
        ch.L0_data = 8'h13; ch.L0_req = 1'b1; push(1'b0, 8'h13);
        token(0, 0);
        ch.L1_data = 8'h24; ch.L1_req = 1'b1; push(1'b1, 8'h24);
        token(0, 0);
        token(0, 0);
        chk("alt_cnt", xfer_cnt, 4'd4);

        // Backpressure on L1 while L0 data wiggles
        ch.L1_data = 8'hC3; ch.L1_req = 1'b1; push(1'b1, 8'hC3);
        token(10, 0);

        // Slow return-to-zero on L0 with L1 waiting
        ch.L0_data = 8'h3C; ch.L1_data = 8'h4B;
        ch.L0_req = 1'b1; ch.L1_req = 1'b1;
        push(1'b0, 8'h3C); push(1'b1, 8'h4B);
        token(0, 5);
        token(0, 0);

        // Async reset while L1 token sits in WAIT_ACK with pointer at L1
        ch.L0_data = 8'h66; ch.L0_req = 1'b1; push(1'b0, 8'h66);
        token(0, 0);
        ch.L1_data = 8'hAB; ch.L1_req = 1'b1;
        @(negedge clk);
        chk("pre_rst_r_req", ch.R_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_r_req",  ch.R_req,  1'b0);
        chk("arst_r_data", ch.R_data, '0);
        chk("arst_l0_ack", ch.L0_ack, 1'b0);
        chk("arst_l1_ack", ch.L1_ack, 1'b0);
        chk("arst_cnt",    xfer_cnt,  '0);
        ch.L1_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        ch.L0_data = 8'h77; ch.L1_data = 8'h88;
        ch.L0_req = 1'b1; ch.L1_req = 1'b1;
        push(1'b0, 8'h77); push(1'b1, 8'h88);
        token(0, 0);
        token(0, 0);

        // Counter wrap with a 4-bit counter
        reset_dut();
        for (int i = 1; i <= 17; i++) begin
            ch.L0_data = W'(i); ch.L0_req = 1'b1; push(1'b0, W'(i));
            token(0, 0);
            if (i == 15) chk("wrap_15", xfer_cnt, 4'd15);
            if (i == 16) chk("wrap_16", xfer_cnt, 4'd0);
        end
        chk("wrap_17", xfer_cnt, 4'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
